// File: rtl/lsu_mem_access.sv
// Memory-access stage: turns decoded load/store controls plus the ALU
// effective address into a single-outstanding req/ack bus transaction.
// Stores are lane-steered with byte strobes; loads are lane-extracted and
// sign/zero extended. Misalignment, illegal width and bus timeout are
// reported as one-cycle faults coincident with the Done pulse.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_Valid_1,
  input  logic        i_Load_1,
  input  logic        i_Store_1,
  input  logic        i_LoadUnsigned_1,
  input  logic [1:0]  i_LoadStoreWidth_2,
  input  logic [31:0] i_Addr_32,
  input  logic [31:0] i_StoreData_32,
  output logic        o_Stall_1,
  output logic        o_Done_1,
  output logic [31:0] o_LoadData_32,
  output logic        o_Fault_1,
  output logic [1:0]  o_FaultCause_2,
  output logic        o_MemReq_1,
  output logic        o_MemWe_1,
  output logic [31:0] o_MemAddr_32,
  output logic [3:0]  o_MemWstrb_4,
  output logic [31:0] o_MemWdata_32,
  input  logic        i_MemAck_1,
  input  logic [31:0] i_MemRdata_32
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_e;

  // Last counter value allowed before a REQ without ack times out.
  localparam int unsigned      TO_M1   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_M1);
  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);

  state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]  lo_q, width_q;
  logic        uns_q;
  logic        req_q, we_q, done_q, fault_q;
  logic [1:0]  cause_q;
  logic [31:0] addr_q, wdata_q, ldata_q;
  logic [3:0]  wstrb_q;

  logic        start, misal;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata, ld_ext;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  assign start = i_Valid_1 & (i_Load_1 | i_Store_1);
  assign misal = ((i_LoadStoreWidth_2 == 2'b01) & i_Addr_32[0]) |
                 ((i_LoadStoreWidth_2 == 2'b10) & (i_Addr_32[1:0] != 2'b00));

  // Store steering: replicate data across lanes, strobe only the addressed bytes
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = i_StoreData_32;
    case (i_LoadStoreWidth_2)
      2'b00: begin
        st_wdata = {4{i_StoreData_32[7:0]}};
        st_wstrb = 4'b0001 << i_Addr_32[1:0];
      end
      2'b01: begin
        st_wdata = {2{i_StoreData_32[15:0]}};
        st_wstrb = i_Addr_32[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   st_wstrb = 4'b1111;
      default: st_wstrb = 4'b0000;
    endcase
  end

  // Load extraction: pick the addressed lane, then sign or zero extend
  always_comb begin
    case (lo_q)
      2'd0:    ld_b = i_MemRdata_32[7:0];
      2'd1:    ld_b = i_MemRdata_32[15:8];
      2'd2:    ld_b = i_MemRdata_32[23:16];
      default: ld_b = i_MemRdata_32[31:24];
    endcase
    ld_h = lo_q[1] ? i_MemRdata_32[31:16] : i_MemRdata_32[15:0];
    case (width_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = i_MemRdata_32;
    endcase
  end

  // Hold upstream while an op is being accepted or the bus is busy
  assign o_Stall_1 = ((state_q == S_IDLE) & start) | (state_q == S_REQ);

  // Transaction FSM with registered bus and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lo_q    <= 2'b00;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'b0000;
      ldata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cause_q <= 2'b00;
          ldata_q <= '0;
          if (start) begin
            if (i_LoadStoreWidth_2 == 2'b11) begin
              state_q <= S_FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              cause_q <= 2'b11;
            end else if (misal) begin
              state_q <= S_FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
              cause_q <= 2'b01;
            end else begin
              // Store wins when both direction bits are set
              state_q <= S_REQ;
              req_q   <= 1'b1;
              we_q    <= i_Store_1;
              addr_q  <= {i_Addr_32[31:2], 2'b00};
              wstrb_q <= i_Store_1 ? st_wstrb : 4'b0000;
              wdata_q <= st_wdata;
              lo_q    <= i_Addr_32[1:0];
              width_q <= i_LoadStoreWidth_2;
              uns_q   <= i_LoadUnsigned_1;
              cnt_q   <= '0;
            end
          end
        end
        S_REQ: begin
          // Ack wins over a timeout landing in the same cycle
          if (i_MemAck_1) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
            if (!we_q) ldata_q <= ld_ext;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state_q <= S_FAULT;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            cause_q <= 2'b10;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE, S_FAULT: begin
          state_q <= S_IDLE;
          cause_q <= 2'b00;
          ldata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_Done_1       = done_q;
  assign o_Fault_1      = fault_q;
  assign o_FaultCause_2 = cause_q;
  assign o_LoadData_32  = ldata_q;
  assign o_MemReq_1     = req_q;
  assign o_MemWe_1      = we_q;
  assign o_MemAddr_32   = addr_q;
  assign o_MemWstrb_4   = wstrb_q;
  assign o_MemWdata_32  = wdata_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: the driver pushes expected bus and
// completion records computed from plain address/lane arithmetic; monitors
// pop and compare whenever the DUT raises a request or a Done pulse.
module tb_lsu_mem_access;
  localparam int TO = 4;

  typedef struct {
    bit          fault;
    logic [1:0]  cause;
    bit          chk_ld;
    logic [31:0] ldata;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_Valid_1 = 0, i_Load_1 = 0, i_Store_1 = 0, i_LoadUnsigned_1 = 0;
  logic [1:0]  i_LoadStoreWidth_2 = 0;
  logic [31:0] i_Addr_32 = 0, i_StoreData_32 = 0, i_MemRdata_32 = 0;
  logic        i_MemAck_1 = 0;
  logic        o_Stall_1, o_Done_1, o_Fault_1, o_MemReq_1, o_MemWe_1;
  logic [1:0]  o_FaultCause_2;
  logic [31:0] o_LoadData_32, o_MemAddr_32, o_MemWdata_32;
  logic [3:0]  o_MemWstrb_4;

  lsu_mem_access #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_Valid_1(i_Valid_1), .i_Load_1(i_Load_1), .i_Store_1(i_Store_1),
    .i_LoadUnsigned_1(i_LoadUnsigned_1), .i_LoadStoreWidth_2(i_LoadStoreWidth_2),
    .i_Addr_32(i_Addr_32), .i_StoreData_32(i_StoreData_32),
    .o_Stall_1(o_Stall_1), .o_Done_1(o_Done_1), .o_LoadData_32(o_LoadData_32),
    .o_Fault_1(o_Fault_1), .o_FaultCause_2(o_FaultCause_2),
    .o_MemReq_1(o_MemReq_1), .o_MemWe_1(o_MemWe_1), .o_MemAddr_32(o_MemAddr_32),
    .o_MemWstrb_4(o_MemWstrb_4), .o_MemWdata_32(o_MemWdata_32),
    .i_MemAck_1(i_MemAck_1), .i_MemRdata_32(i_MemRdata_32)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   total = 0, bad = 0;
  exp_t exp_q[$];
  bus_t bus_q[$];
  int   ack_delay = 99;
  logic [31:0] cur_rdata = 0;
  bit   spur_en = 0;
  int   rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference model: expected completion and bus beat from address arithmetic
  function automatic void model(input bit st, input bit uns, input logic [1:0] w,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] rd, input int dly,
                                output exp_t e, output bus_t b, output bit hb);
    logic [31:0] v;
    int sh;
    e.fault = 0; e.cause = 0; e.chk_ld = 0; e.ldata = 0; e.done_cyc = 0;
    b.addr = 0; b.we = 0; b.wstrb = 0; b.wdata = 0; b.len = 0;
    hb = 0;
    if (w == 2'd3) begin
      e.fault = 1; e.cause = 2'd3; e.chk_ld = 1; e.done_cyc = 1;
    end else if ((w == 2'd1 && (a % 2) != 0) || (w == 2'd2 && (a % 4) != 0)) begin
      e.fault = 1; e.cause = 2'd1; e.chk_ld = 1; e.done_cyc = 1;
    end else begin
      hb = 1;
      b.addr = a - (a % 4);
      b.we = st;
      if (st) begin
        if (w == 2'd0) begin
          b.wdata = 32'(d % 256) * 32'h0101_0101;
          b.wstrb = 4'(32'd1 << (a % 4));
        end else if (w == 2'd1) begin
          b.wdata = 32'(d % 65536) * 32'h0001_0001;
          b.wstrb = 4'(32'd3 << (2 * ((a / 2) % 2)));
        end else begin
          b.wdata = d;
          b.wstrb = 4'hF;
        end
      end
      if (dly >= TO) begin
        b.len = TO; e.fault = 1; e.cause = 2'd2; e.chk_ld = 1; e.done_cyc = TO + 1;
      end else begin
        b.len = dly + 1; e.done_cyc = dly + 2;
        if (!st) begin
          e.chk_ld = 1;
          if (w == 2'd2) v = rd;
          else if (w == 2'd0) begin
            sh = 8 * int'(a % 4);
            v = (rd >> sh) % 256;
            if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
          end else begin
            sh = 16 * int'((a / 2) % 2);
            v = (rd >> sh) % 65536;
            if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
          end
          e.ldata = v;
        end
      end
    end
  endfunction

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus responder: ack after ack_delay REQ cycles; optional spurious acks otherwise
  initial forever begin
    @(posedge clk);
    #2;
    if (o_MemReq_1) begin
      i_MemAck_1    = (rsp_cnt == ack_delay);
      i_MemRdata_32 = i_MemAck_1 ? cur_rdata : $urandom;
      rsp_cnt++;
    end else begin
      rsp_cnt       = 0;
      i_MemAck_1    = spur_en;
      i_MemRdata_32 = $urandom;
    end
  end

  // Monitor: compares bus beats and completions against queued expectations
  bit   prev_req = 0, prev_done = 0, have_b = 0;
  int   reqlen = 0;
  bus_t cur_b;
  exp_t e_m;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      prev_req = 0; prev_done = 0; have_b = 0; reqlen = 0;
    end else begin
      if (o_MemReq_1 && !prev_req) begin
        reqlen = 0;
        if (bus_q.size() == 0) begin
          total++; bad++; have_b = 0;
          $display("FAIL unexpected_req: got req=1 expected req=0 (cycle %0d)", cyc);
        end else begin
          cur_b = bus_q.pop_front();
          have_b = 1;
        end
      end
      if (o_MemReq_1 && have_b) begin
        reqlen++;
        chk("req_addr", o_MemAddr_32, cur_b.addr);
        chk("req_we", 32'(o_MemWe_1), 32'(cur_b.we));
        chk("req_wstrb", 32'(o_MemWstrb_4), 32'(cur_b.wstrb));
        if (cur_b.we) chk("req_wdata", o_MemWdata_32, cur_b.wdata);
        chk("req_stall", 32'(o_Stall_1), 32'd1);
      end
      if (!o_MemReq_1 && prev_req && have_b) begin
        chk("req_len", 32'(reqlen), 32'(cur_b.len));
        have_b = 0;
      end
      if (o_Done_1) begin
        chk("done_pulse", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          e_m = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e_m.done_cyc));
          chk("fault", 32'(o_Fault_1), 32'(e_m.fault));
          if (e_m.fault) chk("fault_cause", 32'(o_FaultCause_2), 32'(e_m.cause));
          if (e_m.chk_ld) chk("load_data", o_LoadData_32, e_m.ldata);
          chk("done_stall", 32'(o_Stall_1), 32'd0);
        end
      end
      if (o_Fault_1 && !o_Done_1) begin
        total++; bad++;
        $display("FAIL fault_without_done: got fault=1 done=0 (cycle %0d)", cyc);
      end
      prev_req  = o_MemReq_1;
      prev_done = o_Done_1;
    end
  end

  // Present one op for a single cycle, then wait (bounded) for its completion.
  // Entered and left at posedge+1.
  task automatic issue(input bit ld, input bit st, input bit uns, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input int dly);
    exp_t e; bus_t b; bit hb; int n;
    model(st, uns, w, a, d, rd, dly, e, b, hb);
    e.done_cyc += cyc;
    exp_q.push_back(e);
    if (hb) bus_q.push_back(b);
    ack_delay = dly;
    cur_rdata = rd;
    i_Valid_1 = 1; i_Load_1 = ld; i_Store_1 = st; i_LoadUnsigned_1 = uns;
    i_LoadStoreWidth_2 = w; i_Addr_32 = a; i_StoreData_32 = d;
    #1 chk("issue_stall", 32'(o_Stall_1), 32'd1);
    @(posedge clk); #1;
    i_Valid_1 = 0; i_Load_1 = 1'($urandom); i_Store_1 = 1'($urandom);
    i_Addr_32 = $urandom; i_StoreData_32 = $urandom;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles (cycle %0d)", cyc);
      exp_q.delete(); bus_q.delete();
    end
    #1;
  endtask

  task automatic idle(input int n, input bit s);
    spur_en = s;
    repeat (n) @(posedge clk);
    #1 spur_en = 0;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e; bus_t b; bit hb;
    logic [1:0] w; logic [31:0] a; int r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(o_MemReq_1), 0);
    chk("rst_done", 32'(o_Done_1), 0);
    chk("rst_fault", 32'(o_Fault_1), 0);
    chk("rst_cause", 32'(o_FaultCause_2), 0);
    chk("rst_ldata", o_LoadData_32, 0);
    chk("rst_stall", 32'(o_Stall_1), 0);
    chk("rst_we", 32'(o_MemWe_1), 0);
    chk("rst_wstrb", 32'(o_MemWstrb_4), 0);
    chk("rst_addr", o_MemAddr_32, 0);
    chk("rst_wdata", o_MemWdata_32, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Directed cases
    issue(1, 0, 0, 2'd0, 32'h1003, 0, 32'h80FF_1234, 0);          // LB
    issue(1, 0, 1, 2'd0, 32'h1003, 0, 32'h80FF_1234, 0);          // LBU
    issue(0, 1, 0, 2'd1, 32'h2002, 32'h0000_ABCD, 0, 3);          // SH, late ack
    issue(1, 0, 0, 2'd2, 32'h3001, 0, 0, 0);                      // LW misaligned
    issue(1, 0, 0, 2'd1, 32'h3003, 0, 0, 0);                      // LH misaligned
    issue(0, 1, 0, 2'd0, 32'h3003, 32'h0000_005A, 0, 0);          // SB top lane
    issue(1, 0, 0, 2'd2, 32'h3000, 0, 32'h1234_5678, 99);         // timeout
    issue(1, 0, 0, 2'd2, 32'h3004, 0, 32'hCAFE_F00D, TO - 1);     // ack on last cycle
    issue(1, 0, 0, 2'd3, 32'h3008, 0, 0, 0);                      // illegal width
    issue(1, 1, 0, 2'd1, 32'h300A, 32'h1357_9BDF, 32'hFFFF, 1);   // both set -> store
    issue(1, 0, 0, 2'd1, 32'h300E, 0, 32'h8001_7FFF, 2);          // LH upper, negative

    // Reset while the request is outstanding
    model(0, 0, 2'd2, 32'h5000, 0, 0, 99, e, b, hb);
    bus_q.push_back(b);
    ack_delay = 99;
    i_Valid_1 = 1; i_Load_1 = 1; i_Store_1 = 0; i_LoadUnsigned_1 = 0;
    i_LoadStoreWidth_2 = 2'd2; i_Addr_32 = 32'h5000;
    @(posedge clk); #1;
    i_Valid_1 = 0;
    @(posedge clk); #3;
    chk("pre_reset_req", 32'(o_MemReq_1), 1);
    rst_n = 0;
    #1;
    chk("reset_req_drop", 32'(o_MemReq_1), 0);
    chk("reset_done", 32'(o_Done_1), 0);
    chk("reset_stall", 32'(o_Stall_1), 0);
    bus_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1, 0, 2'd2, 32'h4000, 32'hDEAD_BEEF, 0, 1);          // SW after reset

    // Back-to-back loads with spurious acks outside REQ
    idle(2, 1);
    spur_en = 1;
    issue(1, 0, 0, 2'd2, 32'h6000, 0, 32'h0102_0304, 0);
    issue(1, 0, 0, 2'd2, 32'h6004, 0, 32'hA5A5_5A5A, 0);
    issue(1, 0, 0, 2'd2, 32'h6008, 0, 32'hFFFF_0000, 0);
    spur_en = 0;

    // Randomized ops
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 7));
      w = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd1) a = a - (a % 2);
        if (w == 2'd2) a = a - (a % 4);
      end
      r = int'($urandom_range(0, 2));
      issue(r != 1, r != 0, 1'($urandom), w, a, $urandom, $urandom,
            int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
